// File: rtl/seq_detector.sv
// seq_detector: serial pattern detector.
//
// This block watches a serial stream of qualified bits. On every consumed bit it compares
// the most recent PAT_LEN bits against PATTERN. The oldest bit is the MSB and the newest
// bit is the LSB. On a hit it raises a one-cycle registered pulse and increments a
// saturating match counter. Matches may overlap, because the history is not flushed
// after a hit.
//
// Ports:
//   clk        rising-edge clock
//   resetN     asynchronous active-low reset
//   syncClear  synchronous clear of history, fill count and counter (wins over bitValid)
//   bitIn      serial data bit
//   bitValid   qualifies bitIn; only qualified bits shift into the history
//   match      one-cycle pulse, registered, high the cycle after the completing bit
//   matchCount saturating count of matches since reset/clear
//   countSat   high while matchCount is all-ones
//
// PAT_LEN must be in 2..16 and CNT_WIDTH must be at least 1.

module seq_detector #(
    parameter int unsigned          PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN   = 4'b1011,
    parameter int unsigned          CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 syncClear,
    input  logic                 bitIn,
    input  logic                 bitValid,
    output logic                 match,
    output logic [CNT_WIDTH-1:0] matchCount,
    output logic                 countSat
);

    // The fill counter must be able to hold PAT_LEN itself.
    localparam int unsigned          FillW    = $clog2(PAT_LEN + 1);
    localparam logic [FillW-1:0]     FillFull = FillW'(PAT_LEN);
    localparam logic [FillW-1:0]     FillPrev = FillW'(PAT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

    logic [PAT_LEN-1:0]   history_q, history_d;
    logic [FillW-1:0]     fill_q, fill_d;
    logic [PAT_LEN-1:0]   shifted;
    logic                 match_d;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 sat_d;

    always_comb begin
        shifted   = {history_q[PAT_LEN-2:0], bitIn};
        history_d = history_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        count_d   = matchCount;

        if (syncClear) begin
            // Any bit presented on a clear cycle is dropped.
            history_d = '0;
            fill_d    = '0;
            count_d   = '0;
        end else if (bitValid) begin
            history_d = shifted;
            if (fill_q != FillFull) begin
                fill_d = fill_q + FillW'(1);
            end
            // The fill guard compares against fill_q, before it is updated. A fill_q of
            // PAT_LEN-1 means this bit is the PAT_LEN-th one. The guard is needed even for
            // all-zero patterns, because the history resets to zero.
            match_d = (shifted == PATTERN) && (fill_q >= FillPrev);
            if (match_d && (matchCount != CntMax)) begin
                count_d = matchCount + CNT_WIDTH'(1);
            end
        end

        sat_d = (count_d == CntMax);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            history_q  <= '0;
            fill_q     <= '0;
            match      <= 1'b0;
            matchCount <= '0;
            countSat   <= 1'b0;
        end else begin
            history_q  <= history_d;
            fill_q     <= fill_d;
            match      <= match_d;
            matchCount <= count_d;
            countSat   <= sat_d;
        end
    end

endmodule
